// File: rtl/l1_icache_pkg.sv
// Shared types for the direct-mapped L1 instruction cache.
package l1_icache_pkg;

  localparam int unsigned NumSets  = 8;
  localparam int unsigned LineBits = 128;
  localparam int unsigned IndexW   = $clog2(NumSets);
  localparam int unsigned TagW     = 16 - 4 - IndexW;

  typedef logic [15:0]         lc3b_word;
  typedef logic [LineBits-1:0] lc3b_datbus;
  typedef logic [IndexW-1:0]   lc3b_c_index;
  typedef logic [TagW-1:0]     lc3b_c_tag;

  typedef enum logic [1:0] {
    IcIdle,
    IcFetch,
    IcFill
  } lc3b_icache_state_t;

endpackage

// File: rtl/l1_icache_if.sv
// Fetch-side and memory-side handshake bundle for the L1 instruction cache.
interface l1_icache_if;
  import l1_icache_pkg::*;

  lc3b_word   cpu_addr;
  logic       cpu_read;
  logic       cpu_resp;
  lc3b_datbus cpu_rdata;
  lc3b_word   mem_addr;
  logic       mem_read;
  logic       mem_resp;
  lc3b_datbus mem_rdata;

  // Cache side.
  modport slave (
    input  cpu_addr, cpu_read, mem_resp, mem_rdata,
    output cpu_resp, cpu_rdata, mem_addr, mem_read
  );

  // Fetch stage plus memory model side.
  modport master (
    output cpu_addr, cpu_read, mem_resp, mem_rdata,
    input  cpu_resp, cpu_rdata, mem_addr, mem_read
  );
endinterface

// File: rtl/l1_icache_array.sv
// Valid/tag/data storage: single write port, combinational read, flushable valid bits.
module l1_icache_array
  import l1_icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        we_i,
  input  lc3b_c_index widx_i,
  input  lc3b_c_tag   wtag_i,
  input  lc3b_datbus  wdata_i,
  input  lc3b_c_index ridx_i,
  output logic        rvalid_o,
  output lc3b_c_tag   rtag_o,
  output lc3b_datbus  rdata_o
);

  logic [NumSets-1:0] valid_q, valid_d;
  lc3b_c_tag          tag_q  [NumSets];
  lc3b_datbus         data_q [NumSets];

  // A fill landing on the flush edge keeps its own valid bit.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) valid_d = '0;
    if (we_i)    valid_d[widx_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped read-only L1 icache: same-cycle hits, one 128-bit line fill per miss.
module l1_icache
  import l1_icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  l1_icache_if.slave  bus
);

  lc3b_icache_state_t state_q;
  lc3b_word           miss_addr_q;
  logic               mem_read_q;

  lc3b_c_index idx;
  lc3b_c_tag   tag;
  logic [3:0]  unused_offset;
  logic        rvalid;
  lc3b_c_tag   rtag;
  lc3b_datbus  rdata;
  logic        hit;
  logic        fill_we;

  assign idx           = bus.cpu_addr[IndexW+3:4];
  assign tag           = bus.cpu_addr[15:IndexW+4];
  assign unused_offset = bus.cpu_addr[3:0];
  assign hit           = rvalid && (rtag == tag);
  // Responses outside FETCH never reach the arrays.
  assign fill_we       = (state_q == IcFetch) && bus.mem_resp;

  l1_icache_array u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .we_i     (fill_we),
    .widx_i   (miss_addr_q[IndexW+3:4]),
    .wtag_i   (miss_addr_q[15:IndexW+4]),
    .wdata_i  (bus.mem_rdata),
    .ridx_i   (idx),
    .rvalid_o (rvalid),
    .rtag_o   (rtag),
    .rdata_o  (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IcIdle;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IcIdle: begin
          if (bus.cpu_read && !hit) begin
            miss_addr_q <= {bus.cpu_addr[15:4], 4'h0};
            mem_read_q  <= 1'b1;
            state_q     <= IcFetch;
          end
        end
        IcFetch: begin
          if (bus.mem_resp) begin
            mem_read_q <= 1'b0;
            state_q    <= IcFill;
          end
        end
        IcFill:  state_q <= IcIdle;
        default: state_q <= IcIdle;
      endcase
    end
  end

  assign bus.cpu_resp  = (state_q == IcIdle) && bus.cpu_read && hit;
  assign bus.cpu_rdata = bus.cpu_resp ? rdata : '0;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_addr  = miss_addr_q;

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: fills, hits, conflicts, address change, flush, reset.
module tb_l1_icache;
  import l1_icache_pkg::*;

  localparam lc3b_datbus L1 = 128'h1111_0001_1111_0002_1111_0003_1111_0004;
  localparam lc3b_datbus L2 = 128'h2222_0001_2222_0002_2222_0003_2222_0004;
  localparam lc3b_datbus L3 = 128'h3333_0001_3333_0002_3333_0003_3333_0004;
  localparam lc3b_datbus L4 = 128'h4444_0001_4444_0002_4444_0003_4444_0004;
  localparam lc3b_datbus L5 = 128'h5555_0001_5555_0002_5555_0003_5555_0004;
  localparam lc3b_datbus L6 = 128'h6666_0001_6666_0002_6666_0003_6666_0004;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_pass;

  l1_icache_if bus ();

  l1_icache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered at the negedge where a missing request is already driven in IDLE.
  task automatic miss_fill(input string tag, input logic [15:0] exp_addr,
                           input logic [127:0] line, input int n_wait);
    @(negedge clk); #1;
    check({tag, " mem_read"}, 128'(bus.mem_read), 128'(1));
    check({tag, " mem_addr"}, 128'(bus.mem_addr), 128'(exp_addr));
    check({tag, " stall"}, 128'(bus.cpu_resp), 128'(0));
    for (int i = 1; i < n_wait; i++) begin
      @(negedge clk); #1;
      check({tag, " mem_read held"}, 128'(bus.mem_read), 128'(1));
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = line;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    check({tag, " fill mem_read"}, 128'(bus.mem_read), 128'(0));
    check({tag, " fill resp"}, 128'(bus.cpu_resp), 128'(0));
    @(negedge clk); #1;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_read  = 1'b0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    #1;
    check("reset cpu_resp", 128'(bus.cpu_resp), 128'(0));
    check("reset mem_read", 128'(bus.mem_read), 128'(0));
    check("reset cpu_rdata", bus.cpu_rdata, 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: cold miss on 0x0010, 3-cycle memory.
    bus.cpu_addr = 16'h0010;
    bus.cpu_read = 1'b1;
    #1;
    check("t1 miss resp", 128'(bus.cpu_resp), 128'(0));
    check("t1 idle mem_read", 128'(bus.mem_read), 128'(0));
    miss_fill("t1", 16'h0010, L1, 3);
    check("t1 hit resp", 128'(bus.cpu_resp), 128'(1));
    check("t1 hit data", bus.cpu_rdata, L1);

    // 2: same line, other offset.
    bus.cpu_addr = 16'h001E;
    #1;
    check("t2 hit resp", 128'(bus.cpu_resp), 128'(1));
    check("t2 hit data", bus.cpu_rdata, L1);
    @(negedge clk); #1;
    check("t2 no mem_read", 128'(bus.mem_read), 128'(0));

    // 3: conflict on index 1.
    bus.cpu_addr = 16'h0090;
    #1;
    check("t3 conflict miss", 128'(bus.cpu_resp), 128'(0));
    miss_fill("t3a", 16'h0090, L2, 1);
    check("t3 hit L2", bus.cpu_rdata, L2);
    bus.cpu_addr = 16'h0010;
    #1;
    check("t3 evicted miss", 128'(bus.cpu_resp), 128'(0));
    miss_fill("t3b", 16'h0010, L1, 2);
    check("t3 refill L1", bus.cpu_rdata, L1);

    // 4: address changes during FETCH.
    bus.cpu_addr = 16'h0200;
    #1;
    check("t4 miss", 128'(bus.cpu_resp), 128'(0));
    @(negedge clk); #1;
    check("t4 mem_addr", 128'(bus.mem_addr), 128'(16'h0200));
    bus.cpu_addr = 16'h0300;
    @(negedge clk); #1;
    check("t4 mem_addr stable", 128'(bus.mem_addr), 128'(16'h0200));
    check("t4 stall", 128'(bus.cpu_resp), 128'(0));
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = L3;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    @(negedge clk); #1;
    check("t4 new addr miss", 128'(bus.cpu_resp), 128'(0));
    miss_fill("t4", 16'h0300, L4, 1);
    check("t4 hit L4", bus.cpu_rdata, L4);

    // 5a: flush in IDLE; resp in the flush cycle is pre-flush.
    bus.cpu_addr = 16'h0010;
    flush        = 1'b1;
    #1;
    check("t5 pre-flush resp", 128'(bus.cpu_resp), 128'(1));
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t5 flushed 0x0010", 128'(bus.cpu_resp), 128'(0));
    bus.cpu_addr = 16'h0300;
    #1;
    check("t5 flushed 0x0300", 128'(bus.cpu_resp), 128'(0));
    miss_fill("t5a", 16'h0300, L4, 1);
    check("t5 refill 0x0300", 128'(bus.cpu_resp), 128'(1));

    // 5b: flush twice in FETCH, the second on the fill edge.
    bus.cpu_addr = 16'h0010;
    #1;
    check("t5b miss", 128'(bus.cpu_resp), 128'(0));
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("t5b mem_addr", 128'(bus.mem_addr), 128'(16'h0010));
    @(negedge clk);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = L5;
    @(negedge clk);
    flush        = 1'b0;
    bus.mem_resp = 1'b0;
    @(negedge clk); #1;
    check("t5b fill survives", 128'(bus.cpu_resp), 128'(1));
    check("t5b fill data", bus.cpu_rdata, L5);
    bus.cpu_addr = 16'h0300;
    #1;
    check("t5b other flushed", 128'(bus.cpu_resp), 128'(0));

    // 6: reset while fetching 0x0300.
    @(negedge clk); #1;
    check("t6 fetching", 128'(bus.mem_read), 128'(1));
    rst_n        = 1'b0;
    bus.cpu_read = 1'b0;
    #1;
    check("t6 async mem_read", 128'(bus.mem_read), 128'(0));
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = L6;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    check("t6 stray ignored", 128'(bus.mem_read), 128'(0));
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 16'h0010;
    #1;
    check("t6 valid cleared", 128'(bus.cpu_resp), 128'(0));
    bus.cpu_addr = 16'h0300;
    #1;
    check("t6 no stray write", 128'(bus.cpu_resp), 128'(0));
    miss_fill("t6", 16'h0300, L6, 1);
    check("t6 final hit", bus.cpu_rdata, L6);
    bus.cpu_read = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
